// File: rtl/bus_slave_mem.sv
// Word-addressed memory target for the shared as_/rw/rdy_ bus.
// Adds WAIT programmable wait states and returns a one-cycle active-low rdy_ pulse.
module bus_slave_mem #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_,
    input  logic        as_,
    input  logic        rw,
    input  logic [29:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        rdy_,
    output logic        busy
);

    localparam int          DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          cnt;
    logic [3:0]          cnt_nxt;

    logic [ADDR_W-1:0]   addr_lat;
    logic                rw_lat;
    logic [31:0]         data_lat;
    logic [31:0]         rd_reg;
    logic [31:0]         mem [DEPTH];

    logic                req;
    logic                enter_ack;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_rw;
    logic [31:0]         acc_data;

    // Upper address bits belong to the bus decoder, not to this array.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^addr[29:ADDR_W];

    assign req = !cs_ && !as_;

    // With WAIT = 0 the array access happens on the capture edge itself,
    // so the access operands come straight from the bus in IDLE.
    assign acc_addr = (state == S_IDLE) ? addr[ADDR_W-1:0] : addr_lat;
    assign acc_rw   = (state == S_IDLE) ? rw               : rw_lat;
    assign acc_data = (state == S_IDLE) ? wr_data          : data_lat;

    // Gated by rst so a request seen while reset is held never touches the array.
    assign enter_ack = rst && (state != S_ACK) && (state_nxt == S_ACK);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cnt_nxt   = WAIT_CNT;
                    state_nxt = (WAIT_CNT == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd1) begin
                    state_nxt = S_ACK;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_IDLE && req) begin
            addr_lat <= addr[ADDR_W-1:0];
            rw_lat   <= rw;
            data_lat <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (enter_ack && acc_rw) begin
            mem[acc_addr] <= acc_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_reg <= 32'h0;
        end else if (enter_ack && !acc_rw) begin
            rd_reg <= mem[acc_addr];
        end
    end

    // Outputs decode from registered state only; rd_data is zero off-ACK for OR-combining.
    assign rdy_    = (state != S_ACK);
    assign busy    = (state != S_IDLE);
    assign rd_data = (state == S_ACK && !rw_lat) ? rd_reg : 32'h0;

endmodule
